// File: rtl/prbs7_checker.sv
// PRBS-7 (x^7+x^6+1) receive checker: self-synchronises to the incoming stream,
// declares lock, then counts bit errors and compared bits; drops lock on error bursts.
module prbs7_checker #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned ERR_WIN    = 64,
  parameter int unsigned ERR_THRESH = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             control,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned MATCH_W = 8;
  localparam int unsigned FILL_W  = 3;
  localparam int unsigned WIN_W   = $clog2(ERR_WIN);
  localparam int unsigned WERR_W  = WIN_W + 1;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [6:0]         s, s_nxt;
  logic [FILL_W-1:0]  fill, fill_nxt;
  logic [MATCH_W-1:0] match, match_nxt;
  logic [WIN_W-1:0]   win, win_nxt;
  logic [WERR_W-1:0]  werr, werr_nxt, werr_inc;
  logic [CNT_W-1:0]   err_cnt_nxt, bit_cnt_nxt;
  logic               pulse_nxt;
  logic               accept;
  logic               pred;
  logic               mismatch;

  assign accept   = control & din_valid;
  assign pred     = s[0] ^ s[6];
  assign mismatch = din ^ pred;
  assign werr_inc = werr + WERR_W'(1);

  // State register; every register holds when no bit is accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      s         <= '0;
      fill      <= '0;
      match     <= '0;
      win       <= '0;
      werr      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      fill      <= fill_nxt;
      match     <= match_nxt;
      win       <= win_nxt;
      werr      <= werr_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= pulse_nxt;
      err_count <= err_cnt_nxt;
      bit_count <= bit_cnt_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt   = state;
    s_nxt       = s;
    fill_nxt    = fill;
    match_nxt   = match;
    win_nxt     = win;
    werr_nxt    = werr;
    err_cnt_nxt = err_count;
    bit_cnt_nxt = bit_count;
    pulse_nxt   = 1'b0;

    if (accept) begin
      case (state)
        SEARCH: begin
          s_nxt = {s[5:0], din};
          if (fill == FILL_W'(6)) begin
            state_nxt = VERIFY;
            fill_nxt  = '0;
            match_nxt = '0;
          end else begin
            fill_nxt = fill + FILL_W'(1);
          end
        end
        VERIFY: begin
          s_nxt = {s[5:0], din};
          // An all-zero register predicts zero forever, so it never counts as a match
          if (!mismatch && (s != 7'd0)) begin
            if (match == MATCH_W'(LOCK_COUNT - 1)) begin
              state_nxt = LOCKED;
              match_nxt = '0;
              win_nxt   = '0;
              werr_nxt  = '0;
            end else begin
              match_nxt = match + MATCH_W'(1);
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a line error is not fed back into s
          s_nxt = {s[5:0], pred};
          if (bit_count != '1) bit_cnt_nxt = bit_count + CNT_W'(1);
          if (mismatch) begin
            pulse_nxt = 1'b1;
            werr_nxt  = werr_inc;
            if (err_count != '1) err_cnt_nxt = err_count + CNT_W'(1);
          end
          if (mismatch && (werr_inc == WERR_W'(ERR_THRESH))) begin
            state_nxt = SEARCH;
            fill_nxt  = '0;
          end else if (win == WIN_W'(ERR_WIN - 1)) begin
            win_nxt  = '0;
            werr_nxt = '0;
          end else begin
            win_nxt = win + WIN_W'(1);
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end

    if (clear) begin
      err_cnt_nxt = '0;
      bit_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_prbs7_checker.sv
// Self-checking bench for prbs7_checker: PRBS generator stimulus with random gating
// and error injection, checked against a queue-based behavioural model.
module tb_prbs7_checker;

  localparam int LOCK_COUNT = 16;
  localparam int ERR_WIN    = 64;
  localparam int ERR_THRESH = 8;
  localparam int CNT_W      = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             control;
  logic             din_valid;
  logic             din;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  int tests_run    = 0;
  int tests_failed = 0;

  prbs7_checker #(
    .LOCK_COUNT(LOCK_COUNT),
    .ERR_WIN   (ERR_WIN),
    .ERR_THRESH(ERR_THRESH),
    .CNT_W     (CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .control  (control),
    .din_valid(din_valid),
    .din      (din),
    .clear    (clear),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  always #5 clock = ~clock;

  // Transmit-side generator
  logic [6:0] gen;

  task automatic gen_bit(output logic b);
    b   = gen[0] ^ gen[6];
    gen = {gen[5:0], b};
  endtask

  // Behavioural model: queue of the last 7 local-sequence bits, mode 0/1/2 = search/verify/locked
  int          m_mode;
  bit          m_hist[$];
  int          m_fill, m_run, m_wpos, m_werr;
  longint      m_errs, m_bits;
  bit          m_pulse;

  task automatic model_reset();
    m_mode = 0;
    m_hist.delete();
    repeat (7) m_hist.push_back(1'b0);
    m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
    m_errs = 0; m_bits = 0; m_pulse = 1'b0;
  endtask

  task automatic model_push(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model_step(input bit b, input bit acc, input bit clr);
    bit p;
    bit all_zero;
    m_pulse = 1'b0;
    if (acc) begin
      p = m_hist[6] ^ m_hist[0];
      all_zero = 1'b1;
      foreach (m_hist[i]) if (m_hist[i]) all_zero = 1'b0;
      if (m_mode == 0) begin
        model_push(b);
        m_fill++;
        if (m_fill == 7) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        model_push(b);
        if (b == p && !all_zero) begin
          m_run++;
          if (m_run == LOCK_COUNT) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
        end else begin
          m_run = 0;
        end
      end else begin
        model_push(p);
        m_bits++;
        if (b != p) begin m_errs++; m_pulse = 1'b1; m_werr++; end
        if (m_werr >= ERR_THRESH) begin
          m_mode = 0; m_fill = 0;
        end else begin
          m_wpos++;
          if (m_wpos == ERR_WIN) begin m_wpos = 0; m_werr = 0; end
        end
      end
    end
    if (clr) begin m_errs = 0; m_bits = 0; end
  endtask

  task automatic drive_bit(input logic b, input logic v, input logic ctl, input logic clr);
    din = b; din_valid = v; control = ctl; clear = clr;
    @(posedge clock);
    model_step(b, v && ctl, clr);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; control = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    gen = 7'h0F;
  endtask

  // Feeds clean generator bits until lock, returning the accepted-bit count (-1 on timeout)
  task automatic acquire(output int n);
    logic b;
    n = -1;
    for (int i = 1; i <= 100 && n < 0; i++) begin
      gen_bit(b);
      drive_bit(b, 1'b1, 1'b1, 1'b0);
      if (locked === 1'b1) n = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; control = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %b want 0", locked); end
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
    tests_run++; if (err_count !== '0) begin tests_failed++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    tests_run++; if (bit_count !== '0) begin tests_failed++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
    reset = 1'b0;
    model_reset();
    gen = 7'h0F;
  endtask

  task automatic test_lock();
    int   lock_at;
    int   drops;
    int   pulses;
    logic b;
    acquire(lock_at);
    tests_run++; if (lock_at != 7 + LOCK_COUNT) begin tests_failed++; $display("FAIL lock_point: got %0d want %0d", lock_at, 7 + LOCK_COUNT); end
    tests_run++; if (bit_count !== '0) begin tests_failed++; $display("FAIL lock_bit_count_at_lock: got %0d want 0", bit_count); end
    drops = 0; pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      gen_bit(b);
      drive_bit(b, 1'b1, 1'b1, 1'b0);
      if (locked !== 1'b1) drops++;
      if (err_pulse === 1'b1) pulses++;
    end
    tests_run++; if (drops != 0) begin tests_failed++; $display("FAIL lock_held: got %0d unlocked cycles want 0", drops); end
    tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL lock_no_pulses: got %0d want 0", pulses); end
    tests_run++; if (err_count !== 32'd0) begin tests_failed++; $display("FAIL lock_err_count: got %0d want 0", err_count); end
    tests_run++; if (bit_count !== 32'd1000) begin tests_failed++; $display("FAIL lock_bit_count: got %0d want 1000", bit_count); end
  endtask

  task automatic test_isolated_errors();
    int   pulses, pulse_wrong, drops;
    logic b, flip;
    drive_bit(1'b0, 1'b0, 1'b1, 1'b1);
    tests_run++; if (bit_count !== 32'd0) begin tests_failed++; $display("FAIL iso_clear_bits: got %0d want 0", bit_count); end
    pulses = 0; pulse_wrong = 0; drops = 0;
    for (int i = 0; i < 200; i++) begin
      gen_bit(b);
      flip = (i == 20 || i == 60 || i == 100);
      drive_bit(b ^ flip, 1'b1, 1'b1, 1'b0);
      if (err_pulse === 1'b1) pulses++;
      if (err_pulse !== flip) pulse_wrong++;
      if (locked !== 1'b1) drops++;
    end
    tests_run++; if (pulses != 3) begin tests_failed++; $display("FAIL iso_pulse_count: got %0d want 3", pulses); end
    tests_run++; if (pulse_wrong != 0) begin tests_failed++; $display("FAIL iso_pulse_timing: got %0d misplaced cycles want 0", pulse_wrong); end
    tests_run++; if (err_count !== 32'd3) begin tests_failed++; $display("FAIL iso_err_count: got %0d want 3", err_count); end
    tests_run++; if (bit_count !== 32'd200) begin tests_failed++; $display("FAIL iso_bit_count: got %0d want 200", bit_count); end
    tests_run++; if (drops != 0) begin tests_failed++; $display("FAIL iso_locked: got %0d unlocked cycles want 0", drops); end
  endtask

  task automatic test_burst_loss();
    int   lock_at, relock, errs, fell_at;
    logic b, flip, pulse_at_fall;
    do_reset();
    acquire(lock_at);
    tests_run++; if (lock_at != 7 + LOCK_COUNT) begin tests_failed++; $display("FAIL burst_lock_point: got %0d want %0d", lock_at, 7 + LOCK_COUNT); end
    errs = 0; fell_at = -1; pulse_at_fall = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      gen_bit(b);
      flip = (k % 2 == 0);
      drive_bit(b ^ flip, 1'b1, 1'b1, 1'b0);
      if (flip) errs++;
      if (locked !== 1'b1 && fell_at < 0) begin fell_at = errs; pulse_at_fall = err_pulse; end
    end
    tests_run++; if (fell_at != ERR_THRESH) begin tests_failed++; $display("FAIL burst_fall_point: got %0d want %0d", fell_at, ERR_THRESH); end
    tests_run++; if (pulse_at_fall !== 1'b1) begin tests_failed++; $display("FAIL burst_pulse_at_fall: got %b want 1", pulse_at_fall); end
    tests_run++; if (err_count !== 32'd8) begin tests_failed++; $display("FAIL burst_err_count: got %0d want 8", err_count); end
    acquire(relock);
    tests_run++; if (relock != 7 + LOCK_COUNT) begin tests_failed++; $display("FAIL burst_relock: got %0d want %0d", relock, 7 + LOCK_COUNT); end
    tests_run++; if (err_count !== 32'd8) begin tests_failed++; $display("FAIL burst_err_retained: got %0d want 8", err_count); end
    tests_run++; if (bit_count !== 32'd15) begin tests_failed++; $display("FAIL burst_bits_retained: got %0d want 15", bit_count); end
  endtask

  task automatic test_all_zero();
    int ever;
    do_reset();
    ever = 0;
    for (int i = 0; i < 500; i++) begin
      drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
      if (locked !== 1'b0) ever++;
    end
    tests_run++; if (ever != 0) begin tests_failed++; $display("FAIL zero_never_locks: got %0d locked cycles want 0", ever); end
    tests_run++; if (err_count !== 32'd0) begin tests_failed++; $display("FAIL zero_err_count: got %0d want 0", err_count); end
    tests_run++; if (bit_count !== 32'd0) begin tests_failed++; $display("FAIL zero_bit_count: got %0d want 0", bit_count); end
  endtask

  task automatic test_gated();
    int               acc, lock_acc, post, gated_changes;
    logic             b, v, ctl;
    logic             p_locked;
    logic [CNT_W-1:0] p_err, p_bits;
    do_reset();
    acc = 0; lock_acc = -1; post = 0; gated_changes = 0;
    for (int cyc = 0; cyc < 800 && post < 100; cyc++) begin
      ctl = !(cyc >= 10 && cyc < 30);
      v   = 1'($urandom_range(0, 1));
      if (v && ctl) gen_bit(b);
      else b = 1'($urandom_range(0, 1));
      p_locked = locked; p_err = err_count; p_bits = bit_count;
      drive_bit(b, v, ctl, 1'b0);
      if (v && ctl) begin
        acc++;
        if (lock_acc >= 0) post++;
      end else if (locked !== p_locked || err_count !== p_err || bit_count !== p_bits || err_pulse !== 1'b0) begin
        gated_changes++;
      end
      if (locked === 1'b1 && lock_acc < 0) lock_acc = acc;
    end
    tests_run++; if (lock_acc != 7 + LOCK_COUNT) begin tests_failed++; $display("FAIL gated_lock_point: got %0d want %0d", lock_acc, 7 + LOCK_COUNT); end
    tests_run++; if (gated_changes != 0) begin tests_failed++; $display("FAIL gated_hold: got %0d changes want 0", gated_changes); end
    tests_run++; if (bit_count !== CNT_W'(post)) begin tests_failed++; $display("FAIL gated_bit_count: got %0d want %0d", bit_count, post); end
    tests_run++; if (err_count !== 32'd0) begin tests_failed++; $display("FAIL gated_err_count: got %0d want 0", err_count); end
  endtask

  task automatic test_random_errors();
    logic b, flip;
    for (int i = 0; i < 400; i++) begin
      gen_bit(b);
      flip = ($urandom_range(0, 99) < 10);
      drive_bit(b ^ flip, 1'b1, 1'b1, 1'b0);
      tests_run++; if (locked !== (m_mode == 2)) begin tests_failed++; $display("FAIL rnd_locked[%0d]: got %b want %b", i, locked, (m_mode == 2)); end
      tests_run++; if (err_pulse !== m_pulse) begin tests_failed++; $display("FAIL rnd_err_pulse[%0d]: got %b want %b", i, err_pulse, m_pulse); end
    end
    tests_run++; if (err_count !== CNT_W'(m_errs)) begin tests_failed++; $display("FAIL rnd_err_count: got %0d want %0d", err_count, m_errs); end
    tests_run++; if (bit_count !== CNT_W'(m_bits)) begin tests_failed++; $display("FAIL rnd_bit_count: got %0d want %0d", bit_count, m_bits); end
  endtask

  task automatic test_clear_on_error();
    int   lock_at;
    logic b;
    do_reset();
    acquire(lock_at);
    repeat (10) begin gen_bit(b); drive_bit(b, 1'b1, 1'b1, 1'b0); end
    gen_bit(b);
    drive_bit(~b, 1'b1, 1'b1, 1'b1);
    tests_run++; if (err_count !== 32'd0) begin tests_failed++; $display("FAIL clr_err_count: got %0d want 0", err_count); end
    tests_run++; if (bit_count !== 32'd0) begin tests_failed++; $display("FAIL clr_bit_count: got %0d want 0", bit_count); end
    tests_run++; if (err_pulse !== 1'b1) begin tests_failed++; $display("FAIL clr_err_pulse: got %b want 1", err_pulse); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL clr_locked: got %b want 1", locked); end
    gen_bit(b);
    drive_bit(b, 1'b1, 1'b1, 1'b0);
    tests_run++; if (bit_count !== 32'd1) begin tests_failed++; $display("FAIL clr_next_bits: got %0d want 1", bit_count); end
  endtask

  task automatic test_reset_mid_lock();
    int   relock;
    logic b;
    repeat (4) begin gen_bit(b); drive_bit(b, 1'b1, 1'b1, 1'b0); end
    gen_bit(b);
    drive_bit(~b, 1'b1, 1'b1, 1'b0);
    tests_run++; if (bit_count !== 32'd6 || err_count !== 32'd1 || err_pulse !== 1'b1) begin
      tests_failed++; $display("FAIL mid_pre_state: got bits=%0d errs=%0d pulse=%b want 6 1 1", bit_count, err_count, err_pulse);
    end
    #3;
    reset = 1'b1;
    #1;
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_locked: got %b want 0", locked); end
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_pulse: got %b want 0", err_pulse); end
    tests_run++; if (err_count !== '0 || bit_count !== '0) begin
      tests_failed++; $display("FAIL mid_reset_counts: got errs=%0d bits=%0d want 0 0", err_count, bit_count);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    gen = 7'h0F;
    acquire(relock);
    tests_run++; if (relock != 7 + LOCK_COUNT) begin tests_failed++; $display("FAIL mid_relock: got %0d want %0d", relock, 7 + LOCK_COUNT); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_isolated_errors();
    test_burst_loss();
    test_all_zero();
    test_gated();
    test_random_errors();
    test_clear_on_error();
    test_reset_mid_lock();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Receive-side companion to the team's PRBS-7 pattern generator; the core of the BERT error-measurement path.
- Takes the serial PRBS-7 bit stream (one bit per qualified clock) and self-synchronises its local sequence to it.
- Declares lock, then counts bit errors and compared bits for BER computation.
- Drops lock and re-synchronises on excessive errors.

Parameters:
- LOCK_COUNT, 16: consecutive correct predictions in VERIFY needed to declare lock (range 1..255).
- ERR_WIN, 64: size of the loss-of-lock observation window, in valid bits (power of 2, 8..1024).
- ERR_THRESH, 8: errors within one window that force loss of lock (1..ERR_WIN).
- CNT_W, 32: width of err_count and bit_count.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- control  input  1  checker enable; when low, inputs are ignored and all state holds.
- din_valid  input  1  din carries a bit this cycle.
- din  input  1  received serial PRBS bit.
- clear  input  1  synchronous clear of err_count and bit_count.
- locked  output  1  high while FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse per detected bit error.
- err_count  output  CNT_W  saturating count of bit errors while locked.
- bit_count  output  CNT_W  saturating count of bits compared while locked.

Behaviour:
- Sequence definition: b[n] = b[n-1] XOR b[n-7] (x^7+x^6+1, period 127).
- 7-bit shift register s shifts left each accepted bit: s <= {s[5:0], in}. s[0] is the newest bit; s[6] is the oldest.
- Prediction: p = s[0] ^ s[6].
- Accepted bit: control & din_valid. With no accepted bit, nothing changes and err_pulse is 0.
- Reset (async) values: s=0, state=SEARCH, fill/match/window counters=0, locked=0, err_pulse=0, err_count=0, bit_count=0.
- FSM states and transitions:
  - SEARCH: shift in din. Fill counter counts to 7; on the 7th accepted bit go to VERIFY with match counter=0.
  - VERIFY: shift in din.
    - din==p and s!=0: match counter +1; on reaching LOCK_COUNT go to LOCKED.
    - Mismatch, or s==0: match counter=0 and stay in VERIFY. An all-zero stream must never lock.
  - LOCKED: shift in p, not din, so one line error is counted exactly once.
    - bit_count +1 for every accepted bit.
    - din!=p: err_count +1, err_pulse=1 next cycle, window error count +1.
    - Window counter wraps at ERR_WIN; window error count resets at the wrap.
    - Window error count reaching ERR_THRESH: go to SEARCH with fill counter=0. This takes precedence over the window wrap on the same bit.
- Outputs are registered. locked and err_pulse change on the clock edge that accepts the deciding bit, i.e. they are visible the cycle after that bit is presented.
- Counters saturate at all-ones and never wrap.
- clear: err_count and bit_count become 0 next edge.
  - clear has priority over a same-cycle increment; that bit is not counted.
  - clear does not affect the FSM, s, or err_pulse.
- Losing lock leaves err_count and bit_count holding their values.
- Reset asserted mid-stream returns everything to reset values immediately. After release the checker re-acquires from SEARCH.

Test Plan:
- Generator seeded 7'h0F feeding its newest bit (din_valid=1, control=1) → locked rises exactly 7+LOCK_COUNT=23 accepted bits after start. err_count stays 0; bit_count=1000 after 1000 further bits.
- Locked stream, invert 3 isolated bits spaced >7 apart → err_count=3, exactly 3 single-cycle err_pulse, locked stays 1.
- Locked stream, invert 8 bits within one 64-bit window → locked falls on the 8th error. Stream clean afterwards → relock after 23 bits; err_count=8 retained.
- Constant din=0 for 500 bits → locked never asserts; err_count=0.
- din_valid toggled 50% and control low for 20 cycles → same lock point and counts as a contiguous stream; no state change while gated.
- clear asserted coincident with an error while locked → err_count=0, err_pulse still 1. Async reset mid-lock → locked=0 and counts=0 immediately.
